// File: rtl/qpp_pingpong_interleaver.sv
// Ping-pong turbo interleaver: one bank fills in natural order while the other
// drains in QPP order, pi(j) = (F1*j + F2*j^2) mod K, generated incrementally.
module qpp_pingpong_interleaver #(
   parameter int unsigned ADDR_W   = 13,
   parameter int unsigned K_SMALL  = 1056,
   parameter int unsigned F1_SMALL = 17,
   parameter int unsigned F2_SMALL = 66,
   parameter int unsigned K_LARGE  = 6144,
   parameter int unsigned F1_LARGE = 263,
   parameter int unsigned F2_LARGE = 480
) (
   input  logic clk,
   input  logic reset,
   input  logic in_valid,
   input  logic in_data,
   input  logic in_start,
   input  logic in_blocksize,
   output logic in_ready,
   output logic out_valid,
   output logic out_data,
   output logic out_start,
   output logic out_end,
   output logic out_blocksize,
   input  logic out_ready,
   output logic start_err
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   localparam logic [ADDR_W:0]   K_S    = (ADDR_W+1)'(K_SMALL);
   localparam logic [ADDR_W:0]   K_L    = (ADDR_W+1)'(K_LARGE);
   localparam logic [ADDR_W-1:0] LAST_S = ADDR_W'(K_SMALL - 1);
   localparam logic [ADDR_W-1:0] LAST_L = ADDR_W'(K_LARGE - 1);
   localparam logic [ADDR_W-1:0] G0_S   = ADDR_W'((F1_SMALL + F2_SMALL) % K_SMALL);
   localparam logic [ADDR_W-1:0] G0_L   = ADDR_W'((F1_LARGE + F2_LARGE) % K_LARGE);
   localparam logic [ADDR_W-1:0] DG_S   = ADDR_W'((2 * F2_SMALL) % K_SMALL);
   localparam logic [ADDR_W-1:0] DG_L   = ADDR_W'((2 * F2_LARGE) % K_LARGE);

   typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} bank_t;
   typedef enum logic {W_IDLE, W_WRITE} wstate_t;
   typedef enum logic [1:0] {R_IDLE, R_PRIME, R_STREAM} rstate_t;

   bank_t   bstate [2];
   logic    bsize  [2];
   wstate_t wstate;
   rstate_t rstate;
   logic    alive;
   logic    wptr;
   logic    rptr;
   logic [ADDR_W-1:0] wcnt;
   logic [ADDR_W-1:0] pi;
   logic [ADDR_W-1:0] g;
   logic [ADDR_W-1:0] j;

   logic mem0 [DEPTH];
   logic mem1 [DEPTH];

   logic              xfer_in, wr_en, wr_last, rd_en, start_rd, nb;
   logic [1:0]        full_now;
   logic [ADDR_W-1:0] wr_addr, wk_last, rk_last, g_delta, ng0, pi_next, g_next;
   logic [ADDR_W:0]   rk, pi_sum, g_sum;

   always_comb begin
      in_ready = alive & ((wstate == W_WRITE) | (bstate[wptr] == B_EMPTY));
      xfer_in  = in_valid & in_ready;
      wk_last  = bsize[wptr] ? LAST_L : LAST_S;
      wr_en    = xfer_in & (in_start | (wstate == W_WRITE));
      wr_addr  = in_start ? '0 : wcnt;
      wr_last  = xfer_in & (wstate == W_WRITE) & !in_start & (wcnt == wk_last);

      // A bank completing this cycle counts as full so draining starts one cycle sooner
      full_now[0] = (bstate[0] == B_FULL) | (wr_last & (wptr == 1'b0));
      full_now[1] = (bstate[1] == B_FULL) | (wr_last & (wptr == 1'b1));

      rk      = out_blocksize ? K_L : K_S;
      rk_last = out_blocksize ? LAST_L : LAST_S;
      g_delta = out_blocksize ? DG_L : DG_S;

      pi_sum  = {1'b0, pi} + {1'b0, g};
      pi_next = (pi_sum >= rk) ? ADDR_W'(pi_sum - rk) : pi_sum[ADDR_W-1:0];
      g_sum   = {1'b0, g} + {1'b0, g_delta};
      g_next  = (g_sum >= rk) ? ADDR_W'(g_sum - rk) : g_sum[ADDR_W-1:0];

      rd_en    = (rstate == R_PRIME) | ((rstate == R_STREAM) & out_ready & !out_end);
      nb       = (rstate == R_IDLE) ? rptr : ~rptr;
      start_rd = full_now[nb] &
                 ((rstate == R_IDLE) | ((rstate == R_STREAM) & out_ready & out_end));
      ng0      = bsize[nb] ? G0_L : G0_S;
   end

   always_ff @(posedge clk) begin
      if (wr_en & !wptr) mem0[wr_addr] <= in_data;
      if (wr_en &  wptr) mem1[wr_addr] <= in_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)      out_data <= 1'b0;
      else if (rd_en) out_data <= rptr ? mem1[pi] : mem0[pi];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         alive         <= 1'b0;
         bstate[0]     <= B_EMPTY;
         bstate[1]     <= B_EMPTY;
         bsize[0]      <= 1'b0;
         bsize[1]      <= 1'b0;
         wstate        <= W_IDLE;
         wptr          <= 1'b0;
         wcnt          <= '0;
         start_err     <= 1'b0;
         rstate        <= R_IDLE;
         rptr          <= 1'b0;
         pi            <= '0;
         g             <= '0;
         j             <= '0;
         out_valid     <= 1'b0;
         out_start     <= 1'b0;
         out_end       <= 1'b0;
         out_blocksize <= 1'b0;
      end else begin
         alive     <= 1'b1;
         start_err <= xfer_in & (((wstate == W_IDLE) & !in_start) |
                                 ((wstate == W_WRITE) & in_start));

         case (wstate)
            W_IDLE: begin
               if (xfer_in & in_start) begin
                  bstate[wptr] <= B_FILLING;
                  bsize[wptr]  <= in_blocksize;
                  wcnt         <= ADDR_W'(1);
                  wstate       <= W_WRITE;
               end
            end
            W_WRITE: begin
               if (xfer_in) begin
                  if (in_start) begin
                     bsize[wptr] <= in_blocksize;
                     wcnt        <= ADDR_W'(1);
                  end else if (wcnt == wk_last) begin
                     bstate[wptr] <= B_FULL;
                     wptr         <= ~wptr;
                     wstate       <= W_IDLE;
                  end else begin
                     wcnt <= wcnt + 1'b1;
                  end
               end
            end
            default: wstate <= W_IDLE;
         endcase

         // pi and g always hold the address and increment for the next read
         case (rstate)
            R_IDLE: ;
            R_PRIME: begin
               out_valid <= 1'b1;
               out_start <= 1'b1;
               out_end   <= 1'b0;
               pi        <= pi_next;
               g         <= g_next;
               rstate    <= R_STREAM;
            end
            R_STREAM: begin
               if (out_ready) begin
                  if (out_end) begin
                     bstate[rptr] <= B_EMPTY;
                     rptr         <= ~rptr;
                     out_valid    <= 1'b0;
                     out_start    <= 1'b0;
                     out_end      <= 1'b0;
                     rstate       <= R_IDLE;
                  end else begin
                     out_start <= 1'b0;
                     out_end   <= ((j + 1'b1) == rk_last);
                     j         <= j + 1'b1;
                     pi        <= pi_next;
                     g         <= g_next;
                  end
               end
            end
            default: rstate <= R_IDLE;
         endcase

         // Placed last so it wins over the FULL/EMPTY updates above for the same bank
         if (start_rd) begin
            bstate[nb]    <= B_DRAINING;
            out_blocksize <= bsize[nb];
            pi            <= '0;
            g             <= ng0;
            j             <= '0;
            rstate        <= R_PRIME;
         end
      end
   end

endmodule

// File: tb/tb_qpp_pingpong_interleaver.sv
// Directed bench for the QPP ping-pong interleaver; expected output bits are
// computed from pi(j) = (f1*j + f2*j*j) mod K and queued per completed block.
module tb_qpp_pingpong_interleaver;

   logic clk = 1'b0;
   logic reset, in_valid, in_data, in_start, in_blocksize, in_ready;
   logic out_valid, out_data, out_start, out_end, out_blocksize, out_ready, start_err;

   always #5 clk = ~clk;

   qpp_pingpong_interleaver #(
      .ADDR_W(13), .K_SMALL(1056), .F1_SMALL(17), .F2_SMALL(66),
      .K_LARGE(6144), .F1_LARGE(263), .F2_LARGE(480)
   ) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_data(in_data), .in_start(in_start),
      .in_blocksize(in_blocksize), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_start(out_start),
      .out_end(out_end), .out_blocksize(out_blocksize), .out_ready(out_ready),
      .start_err(start_err)
   );

   typedef struct {
      bit          d;
      bit          st;
      bit          en;
      bit          bs;
      int unsigned j;
   } exp_t;

   exp_t        q[$];
   exp_t        mon_e;
   bit          data_buf [0:6143];
   int unsigned n_checks = 0, n_pass = 0, n_fail = 0;
   int unsigned done_in = 0, done_out = 0, popped = 0, gap = 0, n_stalls = 0;
   bit          pend_rel = 0, gap_arm = 0, rnd_ready = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int unsigned qpp(input bit bs, input int unsigned jj);
      longint unsigned k, f1, f2;
      k  = bs ? 6144 : 1056;
      f1 = bs ? 263 : 17;
      f2 = bs ? 480 : 66;
      return int'((f1 * jj + f2 * jj * jj) % k);
   endfunction

   task automatic fill_pulse(input int unsigned pos);
      for (int i = 0; i < 6144; i++) data_buf[i] = 1'b0;
      data_buf[pos] = 1'b1;
   endtask

   task automatic fill_lfsr(input logic [15:0] seed);
      logic [15:0] s;
      s = seed;
      for (int i = 0; i < 6144; i++) begin
         data_buf[i] = s[0];
         s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
      end
   endtask

   task automatic drive_bit(input bit d, input bit st, input bit bs, output bit err);
      bit acc;
      int unsigned guard;
      in_valid = 1'b1; in_data = d; in_start = st; in_blocksize = bs;
      acc = 1'b0; guard = 0;
      while (!acc && guard < 20000) begin
         @(negedge clk); #1;
         acc = in_ready;
         if (!acc) begin
            n_stalls++;
            chk("stall_only_when_both_banks_busy", done_in - done_out, 2);
         end
         @(posedge clk); #1;
         guard++;
      end
      if (!acc) chk("in_ready_timeout", acc, 1);
      err = start_err;
   endtask

   task automatic send_block(input bit bs, input int unsigned abort_at, output bit err0);
      int unsigned k;
      bit e;
      k = bs ? 6144 : 1056;
      err0 = 1'b0;
      for (int unsigned i = 0; i < k; i++) begin
         if (abort_at != 0 && i == abort_at) return;
         drive_bit(data_buf[i], i == 0, bs, e);
         if (i == 0) err0 = e;
      end
      for (int unsigned jj = 0; jj < k; jj++)
         q.push_back('{d: data_buf[qpp(bs, jj)], st: jj == 0, en: jj == k - 1, bs: bs, j: jj});
      done_in++;
   endtask

   task automatic wait_drain();
      int unsigned guard;
      guard = 0;
      while (q.size() != 0 && guard < 40000) begin
         @(posedge clk);
         guard++;
      end
      chk("drain_timeout", q.size(), 0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         pend_rel = 1'b0;
         gap_arm  = 1'b0;
      end else begin
         if (pend_rel) begin
            done_out++;
            pend_rel = 1'b0;
         end
         if (gap_arm) begin
            if (out_valid) begin
               chk("block_gap_le_1", gap <= 1, 1);
               gap_arm = 1'b0;
            end else begin
               gap++;
            end
         end
         if (out_valid) begin
            if (q.size() == 0) begin
               chk("spurious_out_valid", out_valid, 0);
            end else begin
               mon_e = q[0];
               chk($sformatf("out j=%0d {bs,end,start,data}", mon_e.j),
                   {out_blocksize, out_end, out_start, out_data},
                   {mon_e.bs, mon_e.en, mon_e.st, mon_e.d});
               if (out_ready) begin
                  void'(q.pop_front());
                  popped++;
                  if (mon_e.en) begin
                     pend_rel = 1'b1;
                     gap_arm  = (q.size() > 0);
                     gap      = 0;
                  end
               end
            end
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "global timeout");
   end

   initial begin
      bit e;
      int unsigned guard;
      reset = 1'b1; in_valid = 1'b0; in_data = 1'b0; in_start = 1'b0; in_blocksize = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_start", out_start, 0);
      chk("rst_out_end", out_end, 0);
      chk("rst_out_blocksize", out_blocksize, 0);
      chk("rst_start_err", start_err, 0);
      reset = 1'b0;
      @(negedge clk);
      chk("in_ready_low_first_cycle", in_ready, 0);
      @(posedge clk); #1;
      chk("in_ready_rises", in_ready, 1);

      // small pulse tests, including the 2-cycle first-output latency
      fill_pulse(83);
      send_block(0, 0, e);
      chk("start_err_clean", e, 0);
      in_valid = 1'b0;
      @(negedge clk);
      chk("latency_cycle1", out_valid, 0);
      @(negedge clk);
      chk("latency_cycle2", out_valid, 1);
      wait_drain();
      fill_pulse(645);
      send_block(0, 0, e);
      in_valid = 1'b0;
      wait_drain();
      fill_pulse(68);
      send_block(0, 0, e);
      in_valid = 1'b0;
      wait_drain();

      // large block, pseudo-random data
      fill_lfsr(16'hACE1);
      send_block(1, 0, e);
      in_valid = 1'b0;
      wait_drain();

      // back-to-back small/large/small with valid held high
      fill_lfsr(16'h1234); send_block(0, 0, e);
      fill_lfsr(16'h5678); send_block(1, 0, e);
      fill_lfsr(16'h9ABC); send_block(0, 0, e);
      in_valid = 1'b0;
      wait_drain();

      // random output backpressure
      rnd_ready = 1'b1;
      n_stalls = 0;
      fill_lfsr(16'h0F0F); send_block(0, 0, e);
      fill_lfsr(16'h3C3C); send_block(0, 0, e);
      fill_lfsr(16'h7007); send_block(0, 0, e);
      in_valid = 1'b0;
      chk("input_stalled_under_backpressure", n_stalls > 0, 1);
      wait_drain();
      rnd_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // data without in_start is dropped
      fill_pulse(0);
      for (int i = 0; i < 3; i++) begin
         drive_bit(1'b1, 1'b0, 1'b0, e);
         chk("drop_start_err", e, 1);
      end
      in_valid = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk("drop_in_ready", in_ready, 1);
      chk("drop_no_output", out_valid, 0);

      // in_start at wcnt=500 of a large block restarts with a small block
      fill_lfsr(16'hBEEF);
      send_block(1, 500, e);
      fill_lfsr(16'hCAFE);
      send_block(0, 0, e);
      chk("abort_start_err", e, 1);
      in_valid = 1'b0;
      wait_drain();

      // reset during drain at j=300
      fill_lfsr(16'h4321);
      popped = 0;
      send_block(0, 0, e);
      in_valid = 1'b0;
      guard = 0;
      while (popped < 300 && guard < 5000) begin
         @(posedge clk); #1;
         guard++;
      end
      chk("reached_j300", popped, 300);
      chk("valid_before_reset", out_valid, 1);
      reset = 1'b1;
      #1;
      chk("reset_clears_out_valid", out_valid, 0);
      chk("reset_clears_in_ready", in_ready, 0);
      q.delete();
      done_in = 0;
      done_out = 0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk); #1;
      chk("post_reset_in_ready", in_ready, 1);
      chk("post_reset_no_output", out_valid, 0);
      fill_lfsr(16'h2468);
      send_block(0, 0, e);
      in_valid = 1'b0;
      wait_drain();

      repeat (5) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
